// File: rtl/sfifo_lowthresh_if.sv
// Handshake bundle for sfifo_lowthresh: write side, read side and low-water threshold.
// slave = the FIFO, master = the producer/consumer driving it.
interface sfifo_lowthresh_if #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
);
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              o_full;
    logic [LGFLEN:0]   o_fill;
    logic              i_rd;
    logic [BW-1:0]     o_data;
    logic              o_empty;
    logic [LGFLEN:0]   i_threshold;
    logic              o_int;

    modport slave (
        input  i_wr, i_data, i_rd, i_threshold,
        output o_full, o_fill, o_data, o_empty, o_int
    );

    modport master (
        output i_wr, i_data, i_rd, i_threshold,
        input  o_full, o_fill, o_data, o_empty, o_int
    );
endinterface

// File: rtl/sfifo_lowthresh.sv
// Synchronous FIFO with a registered low-water flag: o_int is high while the
// FIFO holds at most i_threshold elements, asking the producer to refill.
module sfifo_lowthresh #(
    parameter int BW             = 8,
    parameter int LGFLEN         = 4,
    parameter bit OPT_ASYNC_READ = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    sfifo_lowthresh_if.slave    bus
);
    localparam int FLEN = 1 << LGFLEN;
    localparam int CW   = LGFLEN + 2;

    logic [BW-1:0]   r_mem [0:FLEN-1];
    logic [LGFLEN:0] r_wr_addr = '0;
    logic [LGFLEN:0] r_rd_addr = '0;
    logic            r_int     = 1'b1;

    logic [LGFLEN:0] w_fill;
    logic            w_full;
    logic            w_empty;
    logic            w_wr;
    logic            w_rd;
    logic [LGFLEN:0] w_rd_next;
    logic [CW-1:0]   w_fill_x;
    logic [CW-1:0]   w_thr_x;
    logic [CW-1:0]   w_cmp;

    assign w_fill   = r_wr_addr - r_rd_addr;
    assign w_full   = (w_fill == (LGFLEN+1)'(FLEN));
    assign w_empty  = (w_fill == '0);
    assign w_wr     = bus.i_wr && !w_full && !i_reset;
    assign w_rd     = bus.i_rd && !w_empty && !i_reset;
    assign w_rd_next = i_reset ? '0 : (r_rd_addr + {{LGFLEN{1'b0}}, w_rd});

    assign w_fill_x = {1'b0, w_fill};
    assign w_thr_x  = {1'b0, bus.i_threshold};

    // Fill count the FIFO will hold after this edge, widened so fill+1 cannot wrap.
    always_comb begin
        w_cmp = w_fill_x;
        case ({w_wr, w_rd})
            2'b10:   w_cmp = w_fill_x + CW'(1);
            2'b01:   w_cmp = w_fill_x - CW'(1);
            default: w_cmp = w_fill_x;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_int     <= 1'b1;
        end else begin
            if (w_wr)
                r_wr_addr <= r_wr_addr + 1'b1;
            if (w_rd)
                r_rd_addr <= r_rd_addr + 1'b1;
            r_int <= (w_cmp <= w_thr_x);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_wr_addr[LGFLEN-1:0]] <= bus.i_data;
    end

    generate
        if (OPT_ASYNC_READ) begin : g_async_rd
            assign bus.o_data = r_mem[r_rd_addr[LGFLEN-1:0]];
        end else begin : g_sync_rd
            logic [BW-1:0] r_data = '0;

            // A write landing on the slot that becomes the head must bypass the memory.
            always_ff @(posedge i_clk) begin
                if (w_wr && (r_wr_addr == w_rd_next))
                    r_data <= bus.i_data;
                else
                    r_data <= r_mem[w_rd_next[LGFLEN-1:0]];
            end

            assign bus.o_data = r_data;
        end
    endgenerate

    assign bus.o_fill  = w_fill;
    assign bus.o_full  = w_full;
    assign bus.o_empty = w_empty;
    assign bus.o_int   = r_int;
endmodule

// File: tb/tb_sfifo_lowthresh.sv
// Directed vector table plus a randomized long run against a queue model;
// both read-port variants see identical stimulus and identical expectations.
module tb_sfifo_lowthresh;
    logic i_clk   = 1'b0;
    logic i_reset = 1'b0;

    always #5 i_clk = ~i_clk;

    sfifo_lowthresh_if #(.BW(8), .LGFLEN(4)) if_a ();
    sfifo_lowthresh_if #(.BW(8), .LGFLEN(4)) if_s ();

    sfifo_lowthresh #(.BW(8), .LGFLEN(4), .OPT_ASYNC_READ(1'b1)) u_async (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (if_a)
    );

    sfifo_lowthresh #(.BW(8), .LGFLEN(4), .OPT_ASYNC_READ(1'b0)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (if_s)
    );

    typedef struct {
        bit         rst;
        bit         wr;
        bit         rd;
        logic [7:0] data;
        logic [4:0] thr;
        int         fill;
        bit         empty;
        bit         full;
        bit         intr;
        bit         chkd;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void add(bit rst, bit wr, bit rd, logic [7:0] data, logic [4:0] thr,
                                int fill, bit empty, bit full, bit intr, bit chkd, logic [7:0] dout);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.data = data; v.thr = thr;
        v.fill = fill; v.empty = empty; v.full = full; v.intr = intr;
        v.chkd = chkd; v.dout = dout;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(bit rst, bit wr, bit rd, logic [7:0] data, logic [4:0] thr);
        i_reset = rst;
        if_a.i_wr = wr; if_a.i_rd = rd; if_a.i_data = data; if_a.i_threshold = thr;
        if_s.i_wr = wr; if_s.i_rd = rd; if_s.i_data = data; if_s.i_threshold = thr;
    endtask

    task automatic check_one(string tag, logic [4:0] fill, logic empty, logic full, logic intr,
                             logic [7:0] dout, int e_fill, bit e_empty, bit e_full, bit e_int,
                             bit chkd, logic [7:0] e_dout);
        chk({tag, "_fill"},  int'(fill),  e_fill);
        chk({tag, "_empty"}, int'(empty), int'(e_empty));
        chk({tag, "_full"},  int'(full),  int'(e_full));
        chk({tag, "_int"},   int'(intr),  int'(e_int));
        if (chkd)
            chk({tag, "_data"}, int'(dout), int'(e_dout));
    endtask

    task automatic check_both(string tag, int e_fill, bit e_empty, bit e_full, bit e_int,
                              bit chkd, logic [7:0] e_dout);
        check_one({tag, "_async"}, if_a.o_fill, if_a.o_empty, if_a.o_full, if_a.o_int, if_a.o_data,
                  e_fill, e_empty, e_full, e_int, chkd, e_dout);
        check_one({tag, "_sync"}, if_s.o_fill, if_s.o_empty, if_s.o_full, if_s.o_int, if_s.o_data,
                  e_fill, e_empty, e_full, e_int, chkd, e_dout);
    endtask

    initial begin
        logic [7:0] q[$];
        int         pw;

        // reset, then fill 16 words 0x11..0x20 at threshold 4
        add(1, 0, 0, 8'h00, 5'd4, 0, 1, 0, 1, 0, 8'h00);
        for (int k = 1; k <= 16; k++)
            add(0, 1, 0, 8'(8'h10 + k), 5'd4, k, 0, k == 16, k <= 4, 1, 8'h11);
        // write into full is dropped; read+write on full only reads
        add(0, 1, 0, 8'hAA, 5'd4, 16, 0, 1, 0, 1, 8'h11);
        add(0, 1, 1, 8'hAA, 5'd4, 15, 0, 0, 0, 1, 8'h12);
        // drain 15: o_int rises at fill 4, data in write order
        for (int k = 1; k <= 15; k++)
            add(0, 0, 1, 8'h00, 5'd4, 15 - k, k == 15, 0, (15 - k) <= 4, k < 15, 8'(8'h12 + k));
        // read+write on empty: only the write happens
        add(0, 1, 1, 8'h5A, 5'd4, 1, 0, 0, 1, 1, 8'h5A);
        add(0, 0, 1, 8'h00, 5'd4, 0, 1, 0, 1, 0, 8'h00);
        // fill 8 at threshold 4, then raise threshold to 8
        for (int k = 1; k <= 8; k++)
            add(0, 1, 0, 8'(8'h2F + k), 5'd4, k, 0, 0, k <= 4, 1, 8'h30);
        add(0, 0, 0, 8'h00, 5'd8, 8, 0, 0, 1, 1, 8'h30);
        // threshold 31 keeps o_int high up to full
        for (int k = 1; k <= 8; k++)
            add(0, 1, 0, 8'(8'h37 + k), 5'd31, 8 + k, 0, k == 8, 1, 1, 8'h30);
        // down to fill 10 at threshold 4, then reset with a write pending
        for (int k = 1; k <= 6; k++)
            add(0, 0, 1, 8'h00, 5'd4, 16 - k, 0, 0, 0, 1, 8'(8'h30 + k));
        add(1, 1, 0, 8'h77, 5'd4, 0, 1, 0, 1, 0, 8'h00);
        // threshold 0: flag only when empty
        add(0, 0, 0, 8'h00, 5'd0, 0, 1, 0, 1, 0, 8'h00);
        add(0, 1, 0, 8'h99, 5'd0, 1, 0, 0, 0, 1, 8'h99);
        add(0, 0, 1, 8'h00, 5'd0, 0, 1, 0, 1, 0, 8'h00);

        drive(0, 0, 0, 8'h00, 5'd4);
        #1;
        check_both("powerup", 0, 1, 0, 1, 0, 8'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].data, vecs[i].thr);
            @(posedge i_clk);
            #1;
            check_both($sformatf("v%0d", i), vecs[i].fill, vecs[i].empty, vecs[i].full,
                       vecs[i].intr, vecs[i].chkd, vecs[i].dout);
        end

        // long random run: pointers wrap many times, o_int tracks fill vs last threshold
        pw = 70;
        for (int c = 0; c < 3000; c++) begin
            bit         wr, rd, do_wr, do_rd;
            logic [7:0] d;
            logic [4:0] thr;
            if (c % 150 == 0)
                pw = (pw == 70) ? 30 : 70;
            wr  = ($urandom_range(0, 99) < pw);
            rd  = ($urandom_range(0, 99) < (100 - pw));
            d   = 8'($urandom_range(0, 255));
            thr = 5'($urandom_range(0, 20));
            drive(0, wr, rd, d, thr);
            do_rd = rd && (q.size() > 0);
            do_wr = wr && (q.size() < 16);
            if (do_rd) void'(q.pop_front());
            if (do_wr) q.push_back(d);
            @(posedge i_clk);
            #1;
            check_both($sformatf("r%0d", c), q.size(), q.size() == 0, q.size() == 16,
                       q.size() <= int'(thr), q.size() > 0, (q.size() > 0) ? q[0] : 8'h00);
        end

        drive(0, 0, 0, 8'h00, 5'd4);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
